// File: rtl/uart_word_receiver_pkg.sv
// uart_word_receiver_pkg: shared receiver FSM states and framing constants
// Contents: state_t (IDLE, START, DATA, STOP, WAIT_IDLE), OVERSAMPLE, DATA_BITS
package uart_word_receiver_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with 2-flop synchronizer, 16x tick generator and framing FSM
// Ports: clk, reset_n (async, active low), rxd (raw serial line),
//        byte_out/byte_valid (good byte + strobe), frame_error (bad stop strobe),
//        load/data (cycle-early copy of the byte load for the word assembler),
//        gap_tick (ticks while idle, only with RX_WORD_TIMEOUT_EN)
module uart_rx_byte
    import uart_word_receiver_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_error,
    output logic       load,
    output logic [7:0] data
`ifdef RX_WORD_TIMEOUT_EN
    ,
    output logic       gap_tick
`endif
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    logic [DW-1:0] r_div;
    logic          r_s1, r_s2, r_s3;
    state_t        r_state;
    logic [3:0]    r_sub;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_tick, w_edge, w_idle;
    assign w_tick = (r_div == DW'(DIV - 1));
    assign w_edge = r_s3 & ~r_s2;
    assign w_idle = (r_state == IDLE);
    assign data   = r_shift;
    // Lets the word assembler register the word on the same edge as byte_out.
    assign load   = (r_state == STOP) && w_tick && (r_sub == 4'(OVERSAMPLE - 1)) && r_s2;
`ifdef RX_WORD_TIMEOUT_EN
    assign gap_tick = w_tick & w_idle;
`endif
    // Tick phase restarts on a start edge so mid-bit sampling is aligned to it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1  <= 1'b1;
            r_s2  <= 1'b1;
            r_s3  <= 1'b1;
            r_div <= '0;
        end else begin
            r_s1  <= rxd;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            r_div <= ((w_idle && w_edge) || w_tick) ? '0 : r_div + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_sub       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (r_state)
                IDLE: if (w_edge) begin
                    r_state <= START;
                    r_sub   <= '0;
                end
                START: if (w_tick) begin
                    if (r_sub == 4'(OVERSAMPLE / 2 - 1)) begin
                        r_sub   <= '0;
                        r_bit   <= '0;
                        r_state <= r_s2 ? IDLE : DATA;
                    end else begin
                        r_sub <= r_sub + 4'd1;
                    end
                end
                DATA: if (w_tick) begin
                    r_sub <= r_sub + 4'd1;
                    if (r_sub == 4'(OVERSAMPLE - 1)) begin
                        r_shift <= {r_s2, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'(DATA_BITS - 1)) r_state <= STOP;
                    end
                end
                STOP: if (w_tick) begin
                    r_sub <= r_sub + 4'd1;
                    if (r_sub == 4'(OVERSAMPLE - 1)) begin
                        if (r_s2) begin
                            byte_out   <= r_shift;
                            byte_valid <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            r_state     <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (!r_s2) r_sub <= '0;
                    else if (w_tick) begin
                        r_sub <= r_sub + 4'd1;
                        if (r_sub == 4'(OVERSAMPLE - 1)) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_word_receiver.sv
// uart_word_receiver: UART byte receiver plus little-endian 32-bit word assembly
// Ports: clk, reset_n (async, active low), rxd (8N1 serial, idle high),
//        byte_out/byte_valid, word_out/word_valid, frame_error
// Option: RX_WORD_TIMEOUT_EN clears a partial word after TIMEOUT_BITS idle bit-times
module uart_word_receiver
    import uart_word_receiver_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100000000,
    parameter int BAUD         = 9600,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rxd,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        frame_error
);
    localparam int DIV_RAW = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
    logic        w_load, w_timeout;
    logic [7:0]  w_data;
    logic [1:0]  r_idx;
    logic [23:0] r_buf;
`ifdef RX_WORD_TIMEOUT_EN
    localparam int TLIM = TIMEOUT_BITS * OVERSAMPLE;
    localparam int TW = $clog2(TLIM + 1);
    logic          w_gap_tick;
    logic [TW-1:0] r_tcnt;
    assign w_timeout = w_gap_tick && (r_idx != 2'd0) && (r_tcnt == TW'(TLIM - 1));
    // Counts idle ticks only while a partial word is pending; any frame activity restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_tcnt <= '0;
        else if (r_idx == 2'd0 || w_timeout || (w_gap_tick == 1'b0 && w_load)) r_tcnt <= '0;
        else if (w_gap_tick) r_tcnt <= r_tcnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif
    uart_rx_byte #(.DIV(DIV)) u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .rxd        (rxd),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .frame_error(frame_error),
        .load       (w_load),
        .data       (w_data)
`ifdef RX_WORD_TIMEOUT_EN
        ,
        .gap_tick   (w_gap_tick)
`endif
    );
    // Stale bytes left in r_buf are harmless: each word rewrites lanes 0..2 before use.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx      <= '0;
            r_buf      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (frame_error || w_timeout) r_idx <= '0;
            else if (w_load) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    word_out   <= {w_data, r_buf};
                    word_valid <= 1'b1;
                end else begin
                    r_buf[{r_idx, 3'b000} +: 8] <= w_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_word_receiver.sv
// tb_uart_word_receiver: directed and random frames checked against a queue-based word model
module tb_uart_word_receiver;
    localparam int BIT_CYC = 160;
    localparam int TICK_CYC = 10;
    localparam int TOB = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rxd = 1'b1;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [31:0] word_out;
    logic        word_valid;
    logic        frame_error;

    int n_cmp = 0;
    int n_bad = 0;
    int bv_cnt = 0, wv_cnt = 0, fe_cnt = 0;
    logic pbv = 1'b0, pwv = 1'b0, pfe = 1'b0;

    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_words[$];
    logic [7:0]  m_lane[4];
    int          m_idx = 0;

    always #5 clk = ~clk;

    uart_word_receiver #(.CLK_FREQ_HZ(1600000), .BAUD(10000), .TIMEOUT_BITS(TOB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rxd        (rxd),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .frame_error(frame_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (byte_valid || word_valid || frame_error)
                check("strobe_width", {29'd0, byte_valid & pbv, word_valid & pwv, frame_error & pfe}, 32'd0);
            if (frame_error) check("fe_bv_excl", byte_valid, 1'b0);
            if (word_valid) check("wv_with_bv", byte_valid, 1'b1);
            if (byte_valid) begin
                bv_cnt++;
                check("byte_pending", exp_bytes.size() > 0, 1'b1);
                if (exp_bytes.size() > 0) check("byte_out", byte_out, exp_bytes.pop_front());
            end
            if (word_valid) begin
                wv_cnt++;
                check("word_pending", exp_words.size() > 0, 1'b1);
                if (exp_words.size() > 0) check("word_out", word_out, exp_words.pop_front());
            end
            if (frame_error) fe_cnt++;
        end
        pbv = byte_valid;
        pwv = word_valid;
        pfe = frame_error;
    end

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (good) begin
            exp_bytes.push_back(b);
            m_lane[m_idx] = b;
            if (m_idx == 3) exp_words.push_back({m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_idx = 0;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit good);
        model_byte(b, good);
        rxd = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rxd = good;
        repeat (BIT_CYC) @(negedge clk);
        rxd = 1'b1;
        if (!good) repeat (20 * TICK_CYC) @(negedge clk);
    endtask

    task automatic idle_ticks(input int t);
`ifdef RX_WORD_TIMEOUT_EN
        if (t >= TOB * 16) m_idx = 0;
`endif
        repeat (t * TICK_CYC) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_byte_out", byte_out, 8'h00);
        check("rst_word_out", word_out, 32'h0);
        check("rst_strobes", {byte_valid, word_valid, frame_error}, 3'b000);
        exp_bytes.delete();
        exp_words.delete();
        m_idx = 0;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int bv0, wv0, fe0;
        logic [7:0] rb;
        bit good;
        do_reset();

        bv0 = bv_cnt; wv0 = wv_cnt; fe0 = fe_cnt;
        send(8'h55, 1'b1);
        check("t55_byte", byte_out, 8'h55);
        check("t55_bv_count", bv_cnt - bv0, 1);
        check("t55_no_word", wv_cnt - wv0, 0);
        check("t55_no_fe", fe_cnt - fe0, 0);

        do_reset();
        bv0 = bv_cnt; wv0 = wv_cnt;
        send(8'h78, 1'b1); send(8'h56, 1'b1); send(8'h34, 1'b1); send(8'h12, 1'b1);
        check("w4_word", word_out, 32'h12345678);
        check("w4_bv_count", bv_cnt - bv0, 4);
        check("w4_wv_count", wv_cnt - wv0, 1);

        bv0 = bv_cnt; wv0 = wv_cnt; fe0 = fe_cnt;
        rxd = 1'b0;
        repeat (3 * TICK_CYC) @(negedge clk);
        rxd = 1'b1;
        repeat (30 * TICK_CYC) @(negedge clk);
        check("glitch_no_strobe", (bv_cnt - bv0) + (wv_cnt - wv0) + (fe_cnt - fe0), 0);
        send(8'h5A, 1'b1);
        check("glitch_then_byte", byte_out, 8'h5A);
        check("glitch_word_held", word_out, 32'h12345678);

        do_reset();
        bv0 = bv_cnt; fe0 = fe_cnt;
        send(8'hEE, 1'b1);
        send(8'hAA, 1'b0);
        check("fe_count", fe_cnt - fe0, 1);
        check("fe_byte_kept", byte_out, 8'hEE);
        send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'h04, 1'b1);
        check("fe_word", word_out, 32'h04030201);
        check("fe_bv_count", bv_cnt - bv0, 5);

        do_reset();
        send(8'h3C, 1'b1);
        rb = 8'h9A;
        rxd = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = rb[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rxd = rb[4];
        repeat (BIT_CYC / 2) @(negedge clk);
        do_reset();
        bv0 = bv_cnt;
        idle_ticks(5);
        send(8'hC3, 1'b1);
        check("rst_mid_byte", byte_out, 8'hC3);
        check("rst_mid_bv", bv_cnt - bv0, 1);

        do_reset();
        send(8'h11, 1'b1);
        idle_ticks(80);
        send(8'hDD, 1'b1); send(8'hCC, 1'b1); send(8'hBB, 1'b1); send(8'hAA, 1'b1);
`ifdef RX_WORD_TIMEOUT_EN
        check("timeout_word", word_out, 32'hAABBCCDD);
`else
        check("no_timeout_word", word_out, 32'hBBCCDD11);
`endif

        do_reset();
        for (int k = 0; k < 12; k++) begin
            rb = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send(rb, good);
            if (good) check("rand_byte", byte_out, rb);
        end
        repeat (50) @(negedge clk);
        check("bytes_drained", exp_bytes.size(), 0);
        check("words_drained", exp_words.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
